// File: rtl/led_blink_driver.sv
// led_blink_driver
//   Turns single-cycle event strobes into human-visible LED blinks: each
//   accepted event produces one ON phase of ON_CYCLES followed by a mandatory
//   dark gap of OFF_CYCLES. Sits between core/debug logic and the board LED pin.
//
// Optional feature macro: LED_BLINK_QUEUE_EN
//   defined   : events arriving mid-blink are queued in a saturating pending
//               counter (PEND_W bits) and replayed back-to-back.
//   undefined : no queue; any event while busy is dropped and flags overflow.
//
// Ports
//   clk        in   clock
//   rstn       in   synchronous active-low reset
//   event_i    in   event strobe, one blink requested per high cycle
//   led_o      out  registered LED drive (lit level = ~ACTIVE_LOW)
//   busy_o     out  registered, high while not IDLE
//   done_o     out  registered, one-cycle pulse on return to IDLE
//   overflow_o out  registered, sticky event-dropped flag (cleared by reset)
module led_blink_driver #(
  parameter int unsigned ON_CYCLES  = 10_000_000,
  parameter int unsigned OFF_CYCLES = 10_000_000,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned PEND_W     = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic event_i,
  output logic led_o,
  output logic busy_o,
  output logic done_o,
  output logic overflow_o
);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

  // Elaboration-time parameter sanity check
  if (ON_CYCLES < 1 || OFF_CYCLES < 1 || PEND_W < 1 || CNT_W < 1 ||
      64'(ON_CYCLES) > (64'd1 << CNT_W) ||
      64'(OFF_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_param
    $error("led_blink_driver: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_led;
  logic             r_busy;
  logic             r_done;
  logic             r_overflow;
  logic             w_last_off;
  logic             w_start;
  logic             w_drop;

  assign w_last_off = (r_state == S_OFF) && (r_cnt == OFF_LAST);

`ifdef LED_BLINK_QUEUE_EN
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  logic [PEND_W-1:0] r_pend;
  logic [PEND_W-1:0] w_pend_next;
  logic              w_pend_nz;
  logic              w_inc;
  logic              w_dec;

  assign w_pend_nz = (r_pend != '0);
  assign w_start   = ((r_state == S_IDLE) || w_last_off) && (event_i || w_pend_nz);
  // A start with an empty queue consumes event_i directly, so it is not queued.
  assign w_dec     = w_start && w_pend_nz;
  assign w_inc     = event_i && !(w_start && !w_pend_nz);

  // Saturating pending counter; an increment at max with no decrement is a drop
  always_comb begin
    w_pend_next = r_pend;
    w_drop      = 1'b0;
    if (w_inc && !w_dec) begin
      if (r_pend == PEND_MAX) begin
        w_drop = 1'b1;
      end else begin
        w_pend_next = r_pend + PEND_W'(1);
      end
    end else if (!w_inc && w_dec) begin
      w_pend_next = r_pend - PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_next;
    end
  end
`else
  assign w_start = (r_state == S_IDLE) && event_i;
  assign w_drop  = event_i && (r_state != S_IDLE);
`endif

  // Next-state and phase counter
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = S_ON;
        end
      end
      S_ON: begin
        if (r_cnt == ON_LAST) begin
          w_state_next = S_OFF;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_OFF: begin
        if (w_last_off) begin
          w_state_next = w_start ? S_ON : S_IDLE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register; outputs are registered from the next state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_led      <= ACTIVE_LOW;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_led      <= (w_state_next == S_ON) ^ ACTIVE_LOW;
      r_busy     <= (w_state_next != S_IDLE);
      r_done     <= (r_state == S_OFF) && (w_state_next == S_IDLE);
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign led_o      = r_led;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_led_blink_driver.sv
// tb_led_blink_driver
//   Directed, table-driven bench. Two DUT copies (ACTIVE_LOW 0 and 1) share
//   stimulus. Each scenario is a per-cycle event mask with an optional
//   mid-run reset cycle; cycle c is the interval after the c-th clock edge,
//   inputs driven in cycle c are sampled at the edge that ends it.
//   Expectations cover the queued build (LED_BLINK_QUEUE_EN) or the plain
//   build, whichever this is compiled with.
module tb_led_blink_driver;

  localparam int unsigned ON_C   = 4;
  localparam int unsigned OFF_C  = 3;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PEND_W = 2;

  logic clk;
  logic rstn;
  logic event_i;
  logic led, busy, done, ovf;
  logic led_al, busy_al, done_al, ovf_al;

  led_blink_driver #(
    .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .CNT_W(CNT_W),
    .PEND_W(PEND_W), .ACTIVE_LOW(1'b0)
  ) u_dut (
    .clk(clk), .rstn(rstn), .event_i(event_i),
    .led_o(led), .busy_o(busy), .done_o(done), .overflow_o(ovf)
  );

  led_blink_driver #(
    .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .CNT_W(CNT_W),
    .PEND_W(PEND_W), .ACTIVE_LOW(1'b1)
  ) u_dut_al (
    .clk(clk), .rstn(rstn), .event_i(event_i),
    .led_o(led_al), .busy_o(busy_al), .done_o(done_al), .overflow_o(ovf_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] ev;
    int          rst_cyc;
    int          ncyc;
    int          busy_lo;
    int          busy_hi;
    int          done_cyc;
    int          quiet_lo;
    int          quiet_hi;
  } scen_t;

  typedef struct {
    int   sc;
    int   cyc;
    logic led;
    logic ovf;
  } vec_t;

  scen_t scens[$];
  vec_t  vecs[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic chk(input string name, input int s, input int c,
                     input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s scen %0d cycle %0d: got %b expected %b", name, s, c, act, exp);
    end
  endtask

  function automatic logic [63:0] ev_at(input int c);
    return 64'd1 << c;
  endfunction

  task automatic add_scen(input logic [63:0] ev, input int rst_cyc, input int ncyc,
                          input int busy_lo, input int busy_hi, input int done_cyc,
                          input int quiet_lo, input int quiet_hi);
    scen_t t;
    t.ev = ev; t.rst_cyc = rst_cyc; t.ncyc = ncyc;
    t.busy_lo = busy_lo; t.busy_hi = busy_hi; t.done_cyc = done_cyc;
    t.quiet_lo = quiet_lo; t.quiet_hi = quiet_hi;
    scens.push_back(t);
  endtask

  task automatic add_vec(input int s, input int c, input logic l, input logic o);
    vec_t v;
    v.sc = s; v.cyc = c; v.led = l; v.ovf = o;
    vecs.push_back(v);
  endtask

  // Runs one scenario: reset in cycles 0-1, then events per mask
  task automatic run_scen(input int s);
    scen_t t;
    t = scens[s];
    for (int c = 0; c < t.ncyc; c++) begin
      if (c >= 2) begin
        chk("busy",    s, c, busy,    (c >= t.busy_lo) && (c <= t.busy_hi));
        chk("busy_al", s, c, busy_al, (c >= t.busy_lo) && (c <= t.busy_hi));
        chk("done",    s, c, done,    c == t.done_cyc);
        chk("done_al", s, c, done_al, c == t.done_cyc);
        if (c >= t.quiet_lo && c <= t.quiet_hi) begin
          chk("led_dark",    s, c, led,    1'b0);
          chk("led_al_dark", s, c, led_al, 1'b1);
        end
      end
      foreach (vecs[i]) begin
        if (vecs[i].sc == s && vecs[i].cyc == c) begin
          chk("led",    s, c, led,    vecs[i].led);
          chk("led_al", s, c, led_al, ~vecs[i].led);
          chk("ovf",    s, c, ovf,    vecs[i].ovf);
          chk("ovf_al", s, c, ovf_al, vecs[i].ovf);
        end
      end
      rstn    = (c >= 2) && (c != t.rst_cyc);
      event_i = t.ev[c];
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rstn    = 1'b0;
    event_i = 1'b0;

    // 0: reset values only
    add_scen(64'd0, -1, 6, 1, 0, -1, 2, 5);
    add_vec(0, 2, 1'b0, 1'b0);

    // 1: single event at cycle 10
    add_scen(ev_at(10), -1, 22, 11, 17, 18, 15, 21);
    add_vec(1, 10, 1'b0, 1'b0);
    add_vec(1, 11, 1'b1, 1'b0);
    add_vec(1, 14, 1'b1, 1'b0);
    add_vec(1, 15, 1'b0, 1'b0);

`ifdef LED_BLINK_QUEUE_EN
    // 2: events 10,12,13 -> three back-to-back blinks
    add_scen(ev_at(10) | ev_at(12) | ev_at(13), -1, 36, 11, 31, 32, 29, 35);
    add_vec(2, 14, 1'b1, 1'b0);
    add_vec(2, 15, 1'b0, 1'b0);
    add_vec(2, 17, 1'b0, 1'b0);
    add_vec(2, 18, 1'b1, 1'b0);
    add_vec(2, 21, 1'b1, 1'b0);
    add_vec(2, 22, 1'b0, 1'b0);
    add_vec(2, 24, 1'b0, 1'b0);
    add_vec(2, 25, 1'b1, 1'b0);
    add_vec(2, 28, 1'b1, 1'b0);
    add_vec(2, 32, 1'b0, 1'b0);

    // 3: events 10..14 -> queue saturates, one drop, four blinks
    add_scen(ev_at(10) | ev_at(11) | ev_at(12) | ev_at(13) | ev_at(14),
             -1, 46, 11, 38, 39, 39, 45);
    add_vec(3, 14, 1'b1, 1'b0);
    add_vec(3, 15, 1'b1, 1'b1);
    add_vec(3, 17, 1'b0, 1'b1);
    add_vec(3, 18, 1'b1, 1'b1);
    add_vec(3, 24, 1'b0, 1'b1);
    add_vec(3, 25, 1'b1, 1'b1);
    add_vec(3, 31, 1'b0, 1'b1);
    add_vec(3, 32, 1'b1, 1'b1);
    add_vec(3, 35, 1'b1, 1'b1);
    add_vec(3, 36, 1'b0, 1'b1);
    add_vec(3, 45, 1'b0, 1'b1);

    // 4: event on the last OFF cycle starts the next blink directly
    add_scen(ev_at(10) | ev_at(17), -1, 31, 11, 24, 25, 25, 30);
    add_vec(4, 17, 1'b0, 1'b0);
    add_vec(4, 18, 1'b1, 1'b0);
    add_vec(4, 21, 1'b1, 1'b0);
    add_vec(4, 22, 1'b0, 1'b0);

    // 5: reset mid-blink discards the queued event
    add_scen(ev_at(10) | ev_at(11), 12, 41, 11, 12, -1, 13, 40);
    add_vec(5, 12, 1'b1, 1'b0);
    add_vec(5, 13, 1'b0, 1'b0);
`else
    // 2: second event while busy is dropped
    add_scen(ev_at(10) | ev_at(12), -1, 22, 11, 17, 18, 15, 21);
    add_vec(2, 12, 1'b1, 1'b0);
    add_vec(2, 13, 1'b1, 1'b1);
    add_vec(2, 14, 1'b1, 1'b1);
    add_vec(2, 15, 1'b0, 1'b1);
    add_vec(2, 21, 1'b0, 1'b1);

    // 3: event on the last OFF cycle is still dropped
    add_scen(ev_at(10) | ev_at(17), -1, 24, 11, 17, 18, 15, 23);
    add_vec(3, 17, 1'b0, 1'b0);
    add_vec(3, 18, 1'b0, 1'b1);
    add_vec(3, 20, 1'b0, 1'b1);

    // 4: reset mid-blink clears overflow and stops the blink
    add_scen(ev_at(10) | ev_at(11), 12, 41, 11, 12, -1, 13, 40);
    add_vec(4, 12, 1'b1, 1'b1);
    add_vec(4, 13, 1'b0, 1'b0);
`endif

    @(posedge clk);
    #1;
    for (int s = 0; s < scens.size(); s++) begin
      run_scen(s);
    end
    event_i = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_blink_driver.md
# led_blink_driver

Output-side companion to the push-button debouncer on the FPGA debug board: converts single-cycle event pulses (debounced button flags, error strobes, heartbeat ticks) into human-visible LED blinks of fixed on/off duration. Each accepted event produces exactly one blink. Events arriving while a blink is in progress are queued in a saturating pending counter, so no event is silently lost below the saturation limit. Sits between the core/debug logic and the board LED pins.

## Interface
- ON_CYCLES, 10_000_000 — LED lit duration per blink, in clk cycles (200 ms at 50 MHz); legal 1..2^CNT_W.
- OFF_CYCLES, 10_000_000 — mandatory dark gap after each blink, in clk cycles; legal 1..2^CNT_W.
- CNT_W, 24 — phase counter width.
- PEND_W, 4 — pending-event counter width; saturates at 2^PEND_W-1.
- ACTIVE_LOW, 0 — 1: LED pin is lit when driven 0.

- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- event_i  in  1  event strobe, one blink requested per high cycle.
- led_o  out  1  registered LED pin drive, polarity per ACTIVE_LOW.
- busy_o  out  1  registered, high while state != IDLE.
- done_o  out  1  registered, one-cycle pulse on return to IDLE.
- overflow_o  out  1  sticky, set when an event is dropped; cleared only by reset.

## Operation
- States: IDLE, ON, OFF. Phase counter cnt (CNT_W), pending counter pend (PEND_W).
- start = (state==IDLE or last OFF cycle) and (event_i or pend!=0).
- IDLE: start -> ON, cnt=0.
- ON: cnt increments; cnt==ON_CYCLES-1 -> OFF, cnt=0.
- OFF: cnt increments; cnt==OFF_CYCLES-1 -> ON if start (cnt=0), else IDLE.
- pend_next = pend + event_i - start_from_pend, where start_from_pend = start and pend!=0; if start and event_i both occur with pend!=0, pend unchanged; if start uses event_i directly (pend==0), pend stays 0.
- Increment with pend==2^PEND_W-1 and no decrement in the same cycle: event dropped, pend stays at max, overflow_o set.
- led_o = (state==ON) XOR ACTIVE_LOW, registered from next-state.
- done_o = 1 the first IDLE cycle after an OFF phase.

## Timing
- Reset (rstn low at clk edge): state IDLE, cnt 0, pend 0, led_o = ACTIVE_LOW (dark), busy_o 0, done_o 0, overflow_o 0. Applies mid-blink; queued events discarded.
- Latency: event_i high in cycle t from IDLE -> led lit cycles t+1..t+ON_CYCLES, dark t+ON_CYCLES+1..t+ON_CYCLES+OFF_CYCLES, IDLE + done_o at t+ON_CYCLES+OFF_CYCLES+1.
- Back-to-back queued blinks: dark gap exactly OFF_CYCLES, no IDLE cycle between.
- busy_o high exactly ON_CYCLES+OFF_CYCLES cycles per isolated blink.
- ON_CYCLES=1 / OFF_CYCLES=1 legal: one-cycle phases.

## Configuration
- LED_BLINK_QUEUE_EN defined: pending counter present as above.
- Undefined: no pend register (PEND_W ignored); start = state==IDLE and event_i; any event_i while state != IDLE is dropped and sets overflow_o; return to IDLE after every OFF phase.

## Test plan
Parameters ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2, ACTIVE_LOW=0 unless noted; macro defined unless noted.
- Reset: rstn low cycles 0-1 -> cycle 2 led_o=0, busy_o=0, done_o=0, overflow_o=0; repeat with ACTIVE_LOW=1 -> led_o=1.
- Single event cycle 10 -> led_o=1 cycles 11-14, 0 from 15; busy_o 11-17; done_o=1 only cycle 18.
- Events cycles 10,12,13 -> led_o=1 cycles 11-14, 18-21, 25-28; busy_o continuous 11-31; done_o only cycle 32; overflow_o=0.
- Events cycles 10-14 (five) -> pend saturates at 3 after cycle 13, event 14 dropped, overflow_o=1 from cycle 15 and stays; exactly 4 blinks (starting 11,18,25,32).
- Macro undefined, events cycles 10 and 12 -> one blink cycles 11-14, overflow_o=1 from cycle 13, done_o cycle 18.
- Events cycles 10,11, rstn low cycle 12 -> cycle 13 led_o=0, busy_o=0, pend=0; no further blinks through cycle 40.
